// File: rtl/pipelined_instruction_fetch.sv
// pipelined_instruction_fetch: credit-gated fetch from a 1-cycle synchronous imem into a
// flushable instruction FIFO, with pc-relative and register-relative redirect targets.
module pipelined_instruction_fetch #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4,
   parameter int              IMEM_AW    = 14
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   output logic                          imem_req_o,
   output logic [IMEM_AW-1:0]            imem_addr_o,
   input  logic [31:0]                   imem_rdata_i,
   input  logic                          redirect_i,
   input  logic                          redirect_sel_i,
   input  logic [XLEN-1:0]               redirect_base_pc_i,
   input  logic [XLEN-1:0]               offset_i,
   input  logic [XLEN-1:0]               rD1_i,
   output logic                          id_valid_o,
   input  logic                          id_ready_i,
   output logic [31:0]                   id_inst_o,
   output logic [XLEN-1:0]               id_pc_o,
   output logic [XLEN-1:0]               id_pc_plus_4_o,
   output logic                          misalign_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, raw_target, target;
   logic            inflight_q, misalign_q, push, pop;
   logic [PW-1:0]   rd_q, wr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     inst_mem [FIFO_DEPTH];
   logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];

   // jalr's &~1 never touches bit 1, so bit 1 of the raw sum is the misalign flag for both forms
   assign raw_target = (redirect_sel_i ? rD1_i : redirect_base_pc_i) + offset_i;
   assign target     = {raw_target[XLEN-1:2], 2'b00};

   // Credit counts the in-flight word so the response always has a free slot
   assign imem_req_o  = reset_i && !redirect_i && (int'(count_q) + int'(inflight_q) < FIFO_DEPTH);
   assign imem_addr_o = fetch_pc_q[IMEM_AW+1:2];
   assign push        = inflight_q && !redirect_i;
   assign pop         = id_valid_o && id_ready_i;

   assign id_valid_o     = count_q != '0;
   assign id_inst_o      = inst_mem[rd_q];
   assign id_pc_o        = pc_mem[rd_q];
   assign id_pc_plus_4_o = id_pc_o + XLEN'(4);
   assign misalign_o     = misalign_q;
   assign fifo_count_o   = count_q;

   always_comb begin
      fetch_pc_d = redirect_i ? target : imem_req_o ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      count_d    = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         misalign_q <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= imem_req_o;
         misalign_q <= redirect_i && raw_target[1];
         count_q    <= count_d;
         rd_q       <= redirect_i ? '0 : rd_q + PW'(pop);
         wr_q       <= redirect_i ? '0 : wr_q + PW'(push);
         if (imem_req_o) req_pc_q <= fetch_pc_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         inst_mem[wr_q] <= imem_rdata_i;
         pc_mem[wr_q]   <= req_pc_q;
      end
   end

   assert property (@(posedge clk_i) disable iff (!reset_i)
      !(push && !pop && count_q == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_pipelined_instruction_fetch.sv
// tb_pipelined_instruction_fetch: randomized stimulus against a queue-level fetch model,
// plus directed scenarios pinned with hand-computed values.
module tb_pipelined_instruction_fetch;
   logic        clk = 0, rst_n = 0;
   logic        redirect = 0, sel = 0, ready = 0;
   logic [31:0] base = 0, off = 0, rd1 = 0, rdata = 0;
   logic        imem_req, id_valid, misalign;
   logic [13:0] imem_addr;
   logic [31:0] id_inst, id_pc, id_pc4;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   pipelined_instruction_fetch dut (
      .clk_i(clk), .reset_i(rst_n), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_rdata_i(rdata), .redirect_i(redirect), .redirect_sel_i(sel),
      .redirect_base_pc_i(base), .offset_i(off), .rD1_i(rd1), .id_valid_o(id_valid),
      .id_ready_i(ready), .id_inst_o(id_inst), .id_pc_o(id_pc), .id_pc_plus_4_o(id_pc4),
      .misalign_o(misalign), .fifo_count_o(fifo_count));

   // Instruction memory: mem[i] = 0x1000_0000 + i, one cycle read latency
   always @(posedge clk) if (imem_req) rdata <= 32'h1000_0000 + 32'(imem_addr);

   int total = 0, bad = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   // Reference model: queue of buffered pcs, one optional in-flight pc
   logic [31:0] mq[$];
   logic [31:0] mfpc = 0, minfl_pc = 0, mraw = 0, head = 0;
   bit          minfl = 0, mmis = 0, mreq = 0, mpop = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete(); mfpc = 0; minfl = 0; mmis = 0;
      end else begin
         mpop = mq.size() > 0 && ready;
         mreq = !redirect && (mq.size() + int'(minfl) < 4);
         if (redirect) begin
            mraw = (sel ? rd1 : base) + off;
            mq.delete();
            mfpc = {mraw[31:2], 2'b00};
            mmis = mraw[1];
            minfl = 0;
         end else begin
            if (mpop) void'(mq.pop_front());
            if (minfl) mq.push_back(minfl_pc);
            if (mreq) begin minfl_pc = mfpc; mfpc = mfpc + 4; end
            minfl = mreq;
            mmis = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("req", imem_req, rst_n && !redirect && (mq.size() + int'(minfl) < 4));
      if (imem_req) chk("addr", imem_addr, 32'(mfpc[15:2]));
      chk("valid", id_valid, mq.size() > 0);
      chk("count", fifo_count, mq.size());
      chk("misalign", misalign, mmis);
      if (mq.size() > 0) begin
         head = mq[0];
         chk("id_pc", id_pc, head);
         chk("id_pc4", id_pc4, head + 4);
         chk("id_inst", id_inst, 32'h1000_0000 + 32'(head[15:2]));
      end
   end

   task automatic tick(); @(posedge clk); #2; endtask

   task automatic redir(input bit s, input logic [31:0] b, input logic [31:0] o, input logic [31:0] r);
      sel = s; base = b; off = o; rd1 = r; redirect = 1;
      tick();
      redirect = 0;
   endtask

   task automatic wait_count(input int n);
      for (int k = 0; k < 20 && fifo_count != 3'(n); k++) tick();
      chk("wait_count", fifo_count, n);
   endtask

   initial begin
      ready = 1;
      repeat (3) tick();
      chk("rst_valid", id_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_count", fifo_count, 0);
      rst_n = 1;
      tick(); tick();
      chk("first_valid", id_valid, 1);
      chk("first_pc", id_pc, 32'h0);
      chk("first_inst", id_inst, 32'h1000_0000);
      tick();
      chk("second_pc", id_pc, 32'h4);
      chk("second_pc4", id_pc4, 32'h8);
      repeat (5) tick();
      ready = 0;
      repeat (10) tick();
      chk("sat_count", fifo_count, 4);
      chk("sat_req", imem_req, 0);
      ready = 1;
      repeat (6) tick();
      ready = 0;
      wait_count(3);
      redir(0, 32'h40, 32'hFFFF_FFF0, 0);
      chk("flush_count", fifo_count, 0);
      tick(); tick();
      chk("redir_valid", id_valid, 1);
      chk("redir_pc", id_pc, 32'h30);
      ready = 1;
      repeat (4) tick();
      for (int i = 0; i < 20; i++) begin ready = ($urandom % 3) != 0; tick(); end
      ready = 1;
      redir(1, 0, 0, 32'h103);
      chk("mis_pulse", misalign, 1);
      tick();
      chk("mis_clear", misalign, 0);
      repeat (4) tick();
      redir(1, 0, 0, 32'h101);
      chk("no_mis", misalign, 0);
      tick(); tick();
      chk("jalr_pc", id_pc, 32'h100);
      sel = 0; base = 32'h200; off = 0; redirect = 1;
      tick();
      base = 32'h300;
      tick();
      redirect = 0;
      tick(); tick();
      chk("last_wins_pc", id_pc, 32'h300);
      redir(1, 0, 0, 32'hFFFF_FFFC);
      tick(); tick();
      chk("wrap_pc0", id_pc, 32'hFFFF_FFFC);
      chk("wrap_inst0", id_inst, 32'h1000_3FFF);
      tick();
      chk("wrap_pc1", id_pc, 32'h0);
      for (int i = 0; i < 400; i++) begin
         ready = ($urandom % 4) != 0;
         if ($urandom % 16 == 0) begin
            sel = 1'($urandom); base = $urandom; off = $urandom; rd1 = $urandom; redirect = 1;
         end else redirect = 0;
         tick();
      end
      redirect = 0;
      ready = 0;
      wait_count(4);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", id_valid, 0);
      chk("mid_rst_req", imem_req, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_mis", misalign, 0);
      tick();
      rst_n = 1;
      tick(); tick();
      chk("restart_valid", id_valid, 1);
      chk("restart_pc", id_pc, 32'h0);
      ready = 1;
      repeat (8) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
